bus_uart_tx: RTL
================

// Module: bus_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the shared 8-bit CPU data bus, alongside the timer, IR, mouse,
//  seven-segment, LED and VGA peripherals. The CPU pushes bytes into an internal FIFO and polls a
//  status register. The block serialises the bytes as 8N1 frames on UART_TX for host-side debug logging.
// PARAMETERS
//  BASE_ADDR     8'h80  bus base address; BASE_ADDR+0 = TX data (write), BASE_ADDR+1 = status (read/write)
//  CLKS_PER_BIT  868    CLK cycles per serial bit (100 MHz / 115200); legal range 2..65535
//  FIFO_AW       3      FIFO address width; depth = 2**FIFO_AW entries (8)
// PORTS
//  CLK       in     1  system clock; all state updates on the rising edge
//  RESET     in     1  asynchronous, active-high reset
//  BUS_DATA  inout  8  shared data bus; block drives it only during its read cycle, otherwise 8'hZZ
//  BUS_ADDR  in     8  bus address from the CPU
//  BUS_WE    in     1  bus write enable from the CPU
//  UART_TX   out    1  serial output; idle high
// BEHAVIOUR
//  Reset (async, immediate): UART_TX=1, BUS_DATA=Z, FIFO empty, overflow=0, FSM=IDLE, counters=0.
//  Bus write, BUS_WE=1 at edge N:
//   - ADDR=BASE+0: if FIFO not full (sampled before edge N), BUS_DATA is pushed at edge N.
//     If full, the byte is dropped and overflow is set. A pop in the same cycle does not rescue the push.
//   - ADDR=BASE+1: any data clears overflow at edge N.
//  Bus read, BUS_WE=0 and ADDR=BASE+1 at edge N:
//   - Block registers the status byte and a drive-enable at edge N.
//   - It drives BUS_DATA for the following cycle only, then releases to Z.
//   - Status byte = {4'b0, overflow, busy, empty, full}.
//   - busy = FSM!=IDLE or FIFO non-empty.
//   - Reads of BASE+0 return nothing (bus stays Z).
//  FIFO: circular buffer with FIFO_AW-bit pointers that wrap mod depth, plus a (FIFO_AW+1)-bit count.
//   - full = count==depth; empty = count==0.
//   - Simultaneous push and pop when not full: count unchanged, both pointers advance.
//  TX FSM: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//   - IDLE: UART_TX=1. If FIFO non-empty at an edge: pop the head into the shift register,
//     load baud counter = CLKS_PER_BIT-1, go to START.
//   - START: UART_TX=0 for exactly CLKS_PER_BIT cycles.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index counts 0..7.
//   - STOP: UART_TX=1 for CLKS_PER_BIT cycles. At the terminal count: if FIFO non-empty, pop and
//     go straight to START (no idle gap between frames); else go to IDLE.
//   - Baud counter is 16 bits, counts down; a bit ends when it reaches 0, then it reloads.
//  Latency: push at edge N -> FSM pops at edge N+1 -> UART_TX low from edge N+1. A frame is 10*CLKS_PER_BIT cycles.
//  UART_TX is driven from a register (glitch-free).
//  A write to BASE+0 while a frame is in flight only queues; the current frame is never disturbed.
//  Reset asserted mid-frame: frame truncated, UART_TX high at once, queued bytes discarded.
//  Addresses other than BASE+0/+1 are ignored. Reads never change state.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_AW=3)
//  1. Reset, then write 8'hA5 to 8'h80 -> UART_TX from next edge:
//     0,1,0,1,0,0,1,0,1,1, each held 4 clocks; then idle high.
//  2. Read 8'h81 right after reset -> BUS_DATA=8'h02 for one cycle after the address cycle, then Z.
//  3. Nine back-to-back writes 8'h00..8'h08 with no frame yet started -> 8 bytes queued, 9th dropped.
//     Read 8'h81 returns 8'h0D (overflow, busy, full); 8 frames go out contiguously, 0x00..0x07, no idle gaps.
//  4. Write any value to 8'h81 after test 3 -> next status read has bit3=0.
//  5. Assert RESET 13 clocks into a frame with 3 bytes queued -> UART_TX=1 immediately.
//     After release, status reads 8'h02 and no further frames appear.
//  6. Write to 8'h82 and read 8'h80 -> no FIFO push, BUS_DATA stays Z, UART_TX stays high.

Source files
------------

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the shared 8-bit CPU bus.
// Writes to BASE+0 are queued in a FIFO; BASE+1 exposes status and clears overflow on write.
module bus_uart_tx #(
  parameter logic [7:0]  BASE_ADDR    = 8'h80,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  tri   [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       UART_TX
);

  localparam int unsigned DEPTH       = 1 << FIFO_AW;
  localparam logic [7:0]  STAT_ADDR   = BASE_ADDR + 8'd1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [15:0]        baud, baud_n;
  logic [2:0]         bit_idx, bit_idx_n;
  logic [7:0]         shreg, shreg_n;
  logic               tx, tx_n;
  logic               pop;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, busy, overflow;
  logic               wr_data, wr_stat, rd_stat, push;
  logic [7:0]         status_q;
  logic               drive;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE) || !empty;
  assign wr_data = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign wr_stat = BUS_WE && (BUS_ADDR == STAT_ADDR);
  assign rd_stat = !BUS_WE && (BUS_ADDR == STAT_ADDR);
  // Fullness is judged before the edge, so a same-cycle pop never makes room for this push.
  assign push    = wr_data && !full;

  assign BUS_DATA = drive ? status_q : 'z;
  assign UART_TX  = tx;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= BUS_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      status_q <= '0;
      drive    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_data && full) overflow <= 1'b1;
      else if (wr_stat)    overflow <= 1'b0;
      drive <= rd_stat;
      if (rd_stat) status_q <= {4'b0000, overflow, busy, empty, full};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          baud_n  = BAUD_RELOAD;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n    = BAUD_RELOAD;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          state_n   = DATA;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            baud_n  = BAUD_RELOAD;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            baud_n  = '0;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
